// File: rtl/bus_reg_bank.sv
// Multi-register bus bank with valid/ready command port, zero/carry flags.
// Optional BUSREG_SAT_EN: INC/DEC saturate instead of wrapping.
module bus_reg_bank #(
    parameter int  WIDTH    = 8,
    parameter int  NUM_REGS = 4,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AW-1:0]    cmd_dst,
    input  logic [AW-1:0]    cmd_src,
    input  logic [WIDTH-1:0] bus_in,
    input  logic [AW-1:0]    rd_sel,
    input  logic             n_out_en,
    output logic [WIDTH-1:0] bus_out,
    output logic             wr_done,
    output logic             zero,
    output logic             carry
);

    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_INC  = 3'b010;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_CLR  = 3'b100;
    localparam logic [2:0] OP_MOVE = 3'b101;

    typedef enum logic {
        IDLE,
        MOVE_WR
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   regs_q [NUM_REGS];
    logic [WIDTH-1:0]   temp_q;
    logic [AW-1:0]      mdst_q;
    logic               wr_done_q, zero_q, carry_q;

    logic               accept;
    logic               we;
    logic [AW-1:0]      wdst;
    logic [WIDTH-1:0]   wdata;
    logic               wcarry;
    logic [WIDTH-1:0]   cur;

    assign cmd_ready = (state_q == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign cur       = regs_q[cmd_dst];

    always_comb begin
        state_d = state_q;
        we      = 1'b0;
        wdst    = cmd_dst;
        wdata   = '0;
        wcarry  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            we    = 1'b1;
                            wdata = bus_in;
                        end
                        OP_INC: begin
                            we     = 1'b1;
                            wcarry = (cur == '1);
`ifdef BUSREG_SAT_EN
                            wdata  = wcarry ? cur : cur + WIDTH'(1);
`else
                            wdata  = cur + WIDTH'(1);
`endif
                        end
                        OP_DEC: begin
                            we     = 1'b1;
                            wcarry = (cur == '0);
`ifdef BUSREG_SAT_EN
                            wdata  = wcarry ? cur : cur - WIDTH'(1);
`else
                            wdata  = cur - WIDTH'(1);
`endif
                        end
                        OP_CLR: begin
                            we = 1'b1;
                        end
                        OP_MOVE: begin
                            state_d = MOVE_WR;
                        end
                        default: ;
                    endcase
                end
            end
            MOVE_WR: begin
                we      = 1'b1;
                wdst    = mdst_q;
                wdata   = temp_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            temp_q    <= '0;
            mdst_q    <= '0;
            wr_done_q <= 1'b0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            wr_done_q <= we;
            if (accept && cmd_op == OP_MOVE) begin
                temp_q <= regs_q[cmd_src];
                mdst_q <= cmd_dst;
            end
            if (we) begin
                regs_q[wdst] <= wdata;
                zero_q       <= (wdata == '0);
                carry_q      <= wcarry;
            end
        end
    end

    assign bus_out = n_out_en ? '0 : regs_q[rd_sel];
    assign wr_done = wr_done_q;
    assign zero    = zero_q;
    assign carry   = carry_q;

endmodule

// File: tb/tb_bus_reg_bank.sv
// Self-checking bench for bus_reg_bank: command-level model plus literal checks.
// Honours BUSREG_SAT_EN the same way as the design.
module tb_bus_reg_bank;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [1:0] cmd_dst = 2'd0;
    logic [1:0] cmd_src = 2'd0;
    logic [7:0] bus_in = 8'h00;
    logic [1:0] rd_sel = 2'd0;
    logic       n_out_en = 1'b0;
    logic [7:0] bus_out;
    logic       wr_done, zero, carry;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    bus_reg_bank #(.WIDTH(8), .NUM_REGS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src),
        .bus_in(bus_in), .rd_sel(rd_sel), .n_out_en(n_out_en),
        .bus_out(bus_out), .wr_done(wr_done),
        .zero(zero), .carry(carry)
    );

    always #5 clk = ~clk;

    // Model: register file as a plain array, a move is a pending write.
    logic [7:0] m_regs [4];
    bit         m_zero, m_carry, m_wr;
    bit         mv_pend;
    logic [1:0] mv_dst;
    logic [7:0] mv_val;

    task automatic m_write(input logic [1:0] d, input logic [7:0] v,
                           input bit c);
        m_regs[d] = v;
        m_zero    = (v == 8'h00);
        m_carry   = c;
        m_wr      = 1'b1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        logic [7:0] old;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
            m_zero = 0; m_carry = 0; m_wr = 0; mv_pend = 0;
        end else begin
            m_wr = 1'b0;
            if (mv_pend) begin
                m_write(mv_dst, mv_val, 1'b0);
                mv_pend = 1'b0;
            end else if (cmd_valid) begin
                old = m_regs[cmd_dst];
                case (cmd_op)
                    3'd1: m_write(cmd_dst, bus_in, 1'b0);
`ifdef BUSREG_SAT_EN
                    3'd2: m_write(cmd_dst, (old == 8'hFF) ? old : old + 8'd1,
                                  old == 8'hFF);
                    3'd3: m_write(cmd_dst, (old == 8'h00) ? old : old - 8'd1,
                                  old == 8'h00);
`else
                    3'd2: m_write(cmd_dst, old + 8'd1, old == 8'hFF);
                    3'd3: m_write(cmd_dst, old - 8'd1, old == 8'h00);
`endif
                    3'd4: m_write(cmd_dst, 8'h00, 1'b0);
                    3'd5: begin
                        mv_pend = 1'b1;
                        mv_dst  = cmd_dst;
                        mv_val  = m_regs[cmd_src];
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] got,
                       input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp,
                     $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model cmd_ready", {7'd0, cmd_ready}, {7'd0, !mv_pend});
            chk("model wr_done", {7'd0, wr_done}, {7'd0, m_wr});
            chk("model zero", {7'd0, zero}, {7'd0, m_zero});
            chk("model carry", {7'd0, carry}, {7'd0, m_carry});
            chk("model bus_out", bus_out,
                n_out_en ? 8'h00 : m_regs[rd_sel]);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] d,
                         input logic [1:0] s, input logic [7:0] data);
        bit done = 1'b0;
        cmd_valid = 1'b1;
        cmd_op = op; cmd_dst = d; cmd_src = s; bus_in = data;
        for (int i = 0; i < 10 && !done; i++) begin
            done = cmd_ready;
            step();
        end
        if (!done) chk("accept timeout", 8'd0, 8'd1);
        cmd_valid = 1'b0;
        cmd_op = 3'd0;
    endtask

    task automatic rd(input string name, input logic [1:0] r,
                      input logic [7:0] exp);
        rd_sel = r;
        #1;
        chk(name, bus_out, exp);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        step();
        rst_n = 1'b1;
        step();

        // Reset state
        for (int r = 0; r < 4; r++) rd("reset bus_out", 2'(r), 8'h00);
        chk("reset ready", {7'd0, cmd_ready}, 8'd1);
        chk("reset zero", {7'd0, zero}, 8'd0);
        chk("reset carry", {7'd0, carry}, 8'd0);

        // LOAD r2 = A5
        issue(3'd1, 2'd2, 2'd0, 8'hA5);
        chk("load wr_done", {7'd0, wr_done}, 8'd1);
        chk("load zero", {7'd0, zero}, 8'd0);
        rd("load r2", 2'd2, 8'hA5);
        n_out_en = 1'b1;
        rd("gated r2", 2'd2, 8'h00);
        n_out_en = 1'b0;
        step();
        chk("wr_done one cycle", {7'd0, wr_done}, 8'd0);

        // INC at all-ones
        issue(3'd1, 2'd1, 2'd0, 8'hFF);
        issue(3'd2, 2'd1, 2'd0, 8'h00);
        chk("inc carry", {7'd0, carry}, 8'd1);
`ifdef BUSREG_SAT_EN
        rd("inc r1", 2'd1, 8'hFF);
        chk("inc zero", {7'd0, zero}, 8'd0);
`else
        rd("inc r1", 2'd1, 8'h00);
        chk("inc zero", {7'd0, zero}, 8'd1);
`endif

        // DEC at zero
        issue(3'd4, 2'd3, 2'd0, 8'h00);
        chk("clr zero", {7'd0, zero}, 8'd1);
        issue(3'd3, 2'd3, 2'd0, 8'h00);
        chk("dec carry", {7'd0, carry}, 8'd1);
`ifdef BUSREG_SAT_EN
        rd("dec r3", 2'd3, 8'h00);
        chk("dec zero", {7'd0, zero}, 8'd1);
`else
        rd("dec r3", 2'd3, 8'hFF);
        chk("dec zero", {7'd0, zero}, 8'd0);
`endif

        // Back-to-back INC chain
        issue(3'd1, 2'd0, 2'd0, 8'hFE);
        issue(3'd2, 2'd0, 2'd0, 8'h00);
        issue(3'd2, 2'd0, 2'd0, 8'h00);
`ifdef BUSREG_SAT_EN
        rd("inc chain r0", 2'd0, 8'hFF);
`else
        rd("inc chain r0", 2'd0, 8'h00);
`endif
        chk("inc chain carry", {7'd0, carry}, 8'd1);

        // MOVE with a queued LOAD
        issue(3'd1, 2'd0, 2'd0, 8'h3C);
        issue(3'd5, 2'd3, 2'd0, 8'h00);
        chk("move ready low", {7'd0, cmd_ready}, 8'd0);
        chk("move no wr_done", {7'd0, wr_done}, 8'd0);
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_dst = 2'd2; bus_in = 8'h77;
        step();
        chk("move ready back", {7'd0, cmd_ready}, 8'd1);
        chk("move wr_done", {7'd0, wr_done}, 8'd1);
        chk("move carry", {7'd0, carry}, 8'd0);
        rd("move r3", 2'd3, 8'h3C);
        step();
        cmd_valid = 1'b0; cmd_op = 3'd0;
        rd("queued load r2", 2'd2, 8'h77);
        chk("queued wr_done", {7'd0, wr_done}, 8'd1);

        // MOVE onto itself
        issue(3'd5, 2'd3, 2'd3, 8'h00);
        step();
        rd("self move r3", 2'd3, 8'h3C);
        chk("self move wr_done", {7'd0, wr_done}, 8'd1);

        // MOVE aborted by reset
        issue(3'd1, 2'd1, 2'd0, 8'h5A);
        issue(3'd5, 2'd2, 2'd1, 8'h00);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort wr_done", {7'd0, wr_done}, 8'd0);
            chk("abort ready", {7'd0, cmd_ready}, 8'd1);
            rd("abort r2", 2'd2, 8'h00);
        end

        // Illegal op is a NOP
        issue(3'd1, 2'd0, 2'd0, 8'h81);
        issue(3'd7, 2'd0, 2'd0, 8'h00);
        chk("nop wr_done", {7'd0, wr_done}, 8'd0);
        rd("nop r0", 2'd0, 8'h81);
        step();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_bad);
        $finish;
    end

endmodule

// File: doc/bus_reg_bank.md
# bus_reg_bank

Parametrised multi-register bus bank for the 8-bit breadboard-style CPU datapath. It generalises the single active-low-load bus register into `NUM_REGS` registers of `WIDTH` bits with a valid/ready command port. Commands cover load, increment, decrement, clear and register-to-register move, with zero/carry flags and a gated bus read port. It sits between the shared data bus and the ALU/control sequencer.

## Interface
- `WIDTH`, 8, data width of each register and of the bus (≥2)
- `NUM_REGS`, 4, number of registers (power of two, ≥2); `AW = $clog2(NUM_REGS)` derived localparam
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  bank can accept a command this cycle
- `cmd_op`  in  3  000 NOP, 001 LOAD, 010 INC, 011 DEC, 100 CLR, 101 MOVE, 110/111 treated as NOP
- `cmd_dst`  in  AW  destination register index
- `cmd_src`  in  AW  source register index (MOVE only)
- `bus_in`  in  WIDTH  load data (LOAD only)
- `rd_sel`  in  AW  register driven onto `bus_out`
- `n_out_en`  in  1  active-low output enable
- `bus_out`  out  WIDTH  `reg[rd_sel]` when `n_out_en`=0, else 0; combinational
- `wr_done`  out  1  one-cycle pulse, registered, after any register write
- `zero`  out  1  last written result == 0
- `carry`  out  1  last INC/DEC wrapped (or saturated)

## Operation
- FSM states: IDLE, MOVE_WR. `cmd_ready` = (state == IDLE).
- Accept = `cmd_valid && cmd_ready`. Sample `cmd_op`/`cmd_dst`/`cmd_src`/`bus_in` only on accept.
- LOAD: `reg[dst] <= bus_in` at the accept edge; carry <= 0.
- INC: `reg[dst] <= reg[dst]+1` mod 2^WIDTH; carry <= 1 iff old value was all-ones.
- DEC: `reg[dst] <= reg[dst]-1` mod 2^WIDTH; carry <= 1 iff old value was 0 (borrow).
- CLR: `reg[dst] <= 0`; carry <= 0.
- MOVE: at the accept edge latch `reg[src]` into temp, latch `dst`, go to MOVE_WR. In MOVE_WR `cmd_ready`=0; at the next edge `reg[dst] <= temp`, carry <= 0, return to IDLE. `src == dst` is legal: value unchanged, flags and `wr_done` update.
- `zero` <= (written value == 0) on every write. NOP and illegal ops: no write, no `wr_done`, flags hold.
- `wr_done` is high for exactly the cycle after each write edge.
- `bus_out` reads pre-edge contents; a write becomes visible the cycle after its edge.

## Timing
- Reset (`rst_n`=0, async): all registers 0, state IDLE, `zero`=0, `carry`=0, `wr_done`=0. `cmd_ready`=1 and `bus_out`=0 follow combinationally.
- LOAD/INC/DEC/CLR: 1 cycle; back-to-back accepts every cycle allowed. Throughput 1 per cycle.
- MOVE: 2 cycles; `cmd_ready` low for exactly 1 cycle. A command held valid during MOVE_WR is accepted in the following IDLE cycle.
- Reset during MOVE_WR aborts the move; dst is not written.
- Back-to-back INC on the same register chains correctly, because each accept reads the updated value.

## Configuration
- `BUSREG_SAT_EN` defined: INC at all-ones holds all-ones, DEC at 0 holds 0, carry <= 1 in both cases; `zero` reflects the held value.
- `BUSREG_SAT_EN` undefined: INC/DEC wrap modulo 2^WIDTH as above.

## Test plan
- Reset then `n_out_en`=0, `rd_sel`=0..3 -> `bus_out`=0x00 for all; `cmd_ready`=1, flags 0.
- LOAD r2=0xA5 -> next cycle `wr_done`=1, `zero`=0; `rd_sel`=2 gives 0xA5; `n_out_en`=1 gives 0x00.
- LOAD r1=0xFF, INC r1 -> r1=0x00, `carry`=1, `zero`=1. With `BUSREG_SAT_EN`: r1=0xFF, `carry`=1, `zero`=0.
- CLR r3, DEC r3 -> r3=0xFF, `carry`=1. With `BUSREG_SAT_EN`: r3=0x00, `zero`=1.
- LOAD r0=0x3C, MOVE r0->r3 with `cmd_valid` held and a following LOAD queued -> `cmd_ready`=0 for 1 cycle; r3=0x3C; queued LOAD accepted the cycle after.
- MOVE r1->r2 with `rst_n` pulsed low in MOVE_WR -> r2=0, state IDLE, `wr_done` never asserts.
